// File: rtl/counter_pkg.sv
// Shared types and width limits for the modulo counter family.
// Optional saturate mode is enabled by defining COUNTER_SAT_EN.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int COUNTER_MIN_WIDTH = 1;
    localparam int COUNTER_MAX_WIDTH = 16;

    // True when a WIDTH/MAX_VAL pair describes a buildable counter.
    function automatic bit counter_params_ok(input int width, input int max_val);
        bit ok;
        ok = (width >= COUNTER_MIN_WIDTH) && (width <= COUNTER_MAX_WIDTH);
        if (ok) begin
            ok = (max_val >= 1) && (max_val <= ((1 << width) - 1));
        end
        return ok;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and wrap detection for mod_counter.
// Saturate-at-bound behaviour is compiled in only when COUNTER_SAT_EN is defined.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count_next,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    dir_t dir;
    logic at_bound;
    logic hold_at_bound;

    assign dir      = dir_t'(up);
    assign at_bound = (dir == DIR_UP) ? (count == MAX_C) : (count == ZERO_C);

`ifdef COUNTER_SAT_EN
    assign hold_at_bound = sat;
`else
    assign hold_at_bound = 1'b0;
`endif

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            // Loads above the terminal value clamp, keeping count in range.
            count_next = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            if (at_bound) begin
                if (!hold_at_bound) begin
                    count_next = (dir == DIR_UP) ? ZERO_C : MAX_C;
                    wrap_next  = 1'b1;
                end
            end else if (dir == DIR_UP) begin
                count_next = count + ONE_C;
            end else begin
                count_next = count - ONE_C;
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with clamped load, registered wrap pulse and sticky overflow.
// Define COUNTER_SAT_EN to add the sat port (hold at bound instead of wrapping).
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
`ifdef COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf
);

    if (!counter_params_ok(WIDTH, MAX_VAL)) begin : g_param_check
        $error("mod_counter: illegal WIDTH=%0d / MAX_VAL=%0d", WIDTH, MAX_VAL);
    end

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count      (count),
        .up         (up),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
`ifdef COUNTER_SAT_EN
        .sat        (sat),
`endif
        .count_next (count_next),
        .wrap_next  (wrap_next)
    );

    // A wrap on the same edge as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
            ovf   <= wrap_next | (ovf & ~clr_ovf);
        end
    end

endmodule
